// File: rtl/instr_fetch_queue_if.sv
// Signal bundle between the PC, the synchronous instruction memory, decode and the fetch queue.
// slave is the fetch queue's view; master is the surrounding environment's view.
interface instr_fetch_queue_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  instr_address;
  logic               branch;
  logic               pc_stall;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport slave (
    input  instr_address, branch, imem_rdata, out_ready,
    output pc_stall, imem_addr, out_valid, out_instr, out_pc
  );

  modport master (
    output instr_address, branch, imem_rdata, out_ready,
    input  pc_stall, imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues the PC address to a synchronous imem and buffers returned words with their PCs.
// Issue is credit-gated so that a word in flight always has a free FIFO slot waiting for it.
module instr_fetch_queue #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input logic                clk_i,
  input logic                rst_n_i,
  instr_fetch_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]      credit;
  logic               pop, push, issue;

  always_comb begin
    pop    = (count_q != '0) & bus.out_ready;
    // Slots already claimed by stored words plus the outstanding fetch; never underflows
    // because pop implies count_q >= 1.
    credit = count_q + CW'(inflight_q) - CW'(pop);
    issue  = ~bus.branch & (credit < CW'(DEPTH));
    push   = inflight_q & ~bus.branch;

    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? bus.instr_address : inflight_pc_q;

    if (bus.branch) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: bus.imem_rdata};
    end
  end

  assign bus.pc_stall  = ~issue;
  assign bus.imem_addr = bus.instr_address;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
endmodule
